// File: rtl/lifo_frame_unloader.sv
// Frame-reversal controller driving an external LIFO through PUSH/POP strobes.
// Optional macro LIFO_FRAME_UNLOADER_OVF_EN: truncate over-long frames and flag ovf_err.
module lifo_frame_unloader #(
   parameter int DATA_WIDTH = 8,
   parameter int LIFO_DEPTH = 16
) (
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
   output logic                  ovf_err,
`endif
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  PUSH,
   output logic                  POP,
   output logic [DATA_WIDTH-1:0] dataIn,
   input  logic [DATA_WIDTH-1:0] dataOut,
   input  logic                  EMPTY,
   input  logic                  FULL
);

   localparam int CW = $clog2(LIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(LIFO_DEPTH);

   typedef enum logic [1:0] {ST_FILL, ST_POP, ST_CAPT, ST_SEND} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          accept;
   logic          room;

   assign room   = (count < DEPTH_C);
   assign accept = in_valid & in_ready;

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      in_ready = 1'b0;
      if (!Rst && state == ST_FILL) begin
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
         in_ready = !room | !FULL;
`else
         in_ready = room & !FULL;
`endif
      end
   end

   // Words accepted once the stack holds LIFO_DEPTH are swallowed, never pushed.
   assign PUSH   = accept & room;
   assign POP    = (state == ST_POP) & !EMPTY & !Rst;
   assign dataIn = Rst ? '0 : in_data;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= ST_FILL;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
         ovf_err   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_FILL: begin
               if (accept) begin
                  if (room) count <= count + 1'b1;
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
                  else      ovf_err <= 1'b1;
                  if (in_last) state <= ST_POP;
`else
                  if (in_last || count == DEPTH_C - 1'b1) state <= ST_POP;
`endif
               end
            end
            ST_POP: begin
               // An empty stack here means the frame bookkeeping is lost; abandon the drain.
               if (EMPTY) begin
                  count <= '0;
                  state <= ST_FILL;
               end else begin
                  count <= count - 1'b1;
                  state <= ST_CAPT;
               end
            end
            ST_CAPT: begin
               out_data  <= dataOut;
               out_valid <= 1'b1;
               out_last  <= (count == '0);
               state     <= ST_SEND;
            end
            ST_SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= (count == '0) ? ST_FILL : ST_POP;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_frame_unloader.sv
// Bench for lifo_frame_unloader with a behavioural stack and a frame-level reversal model.
// Build with LIFO_FRAME_UNLOADER_OVF_EN defined to exercise the truncating variant.
module tb_lifo_frame_unloader;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   typedef logic [DW:0] beat_t;   // {last, data}

   logic          Clk = 1'b0;
   logic          Rst;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic          PUSH, POP, EMPTY, FULL;
   logic [DW-1:0] dataIn, dataOut;
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
   logic          ovf_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   lifo_frame_unloader #(.DATA_WIDTH(DW), .LIFO_DEPTH(DEPTH)) dut (
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
      .ovf_err  (ovf_err),
`endif
      .Clk      (Clk),
      .Rst      (Rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .PUSH     (PUSH),
      .POP      (POP),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .EMPTY    (EMPTY),
      .FULL     (FULL)
   );

   // Passive stack: read data appears the cycle after POP.
   logic [DW-1:0] mem [DEPTH];
   int            sp;
   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sp      <= 0;
         dataOut <= '0;
      end else if (PUSH && sp < DEPTH) begin
         mem[sp] <= dataIn;
         sp      <= sp + 1;
      end else if (POP && sp > 0) begin
         dataOut <= mem[sp-1];
         sp      <= sp - 1;
      end
   end
   assign EMPTY = (sp == 0);
   assign FULL  = (sp == DEPTH);

   // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
   int rdy_mode = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: records handshaken beats and protocol violations.
   beat_t got[$];
   int    stab_viol = 0, pushpop_viol = 0, popsend_viol = 0;
   logic  prev_stall = 1'b0;
   beat_t prev_beat  = '0;
   always @(negedge Clk) begin
      if (Rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!out_valid || {out_last, out_data} !== prev_beat)) stab_viol++;
         if (PUSH && POP) pushpop_viol++;
         if (POP && out_valid) popsend_viol++;
         if (out_valid && out_ready) got.push_back({out_last, out_data});
         prev_stall = out_valid && !out_ready;
         prev_beat  = {out_last, out_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: each stored chunk comes back reversed, last flag on its first-received word.
   function automatic void build_expect(input logic [DW-1:0] f[$], output beat_t e[$]);
      int n;
      e.delete();
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
      n = (f.size() < DEPTH) ? f.size() : DEPTH;
      for (int j = n - 1; j >= 0; j--) e.push_back({(j == 0), f[j]});
`else
      for (int s = 0; s < f.size(); s += DEPTH) begin
         n = (f.size() - s < DEPTH) ? f.size() - s : DEPTH;
         for (int j = n - 1; j >= 0; j--) e.push_back({(j == 0), f[s + j]});
      end
`endif
   endfunction

   // Returns one time unit after the edge that accepted the final word.
   task automatic drive_frame(input logic [DW-1:0] f[$], input bit gaps);
      int waits;
      int g;
      @(posedge Clk);
      #1;
      for (int i = 0; i < f.size(); i++) begin
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin
            @(posedge Clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = f[i];
         in_last  = (i == f.size() - 1);
         waits    = 0;
         @(negedge Clk);
         while (!in_ready && waits < 300) begin
            waits++;
            @(negedge Clk);
         end
         if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(posedge Clk);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic collect(input int base, input beat_t e[$], input string tag);
      int waits = 0;
      while (got.size() - base < e.size() && waits < 3000) begin
         @(negedge Clk);
         waits++;
      end
      repeat (8) @(negedge Clk);
      check({tag, "_count"}, 32'(got.size() - base), 32'(e.size()));
      for (int k = 0; k < e.size() && base + k < got.size(); k++)
         check($sformatf("%s_beat%0d", tag, k), 32'(got[base + k]), 32'(e[k]));
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_frame(input logic [DW-1:0] f[$], input bit gaps, input string tag);
      beat_t e[$];
      int    base;
      base = got.size();
      build_expect(f, e);
      drive_frame(f, gaps);
      collect(base, e, tag);
   endtask

   initial begin
      logic [DW-1:0] f[$];
      beat_t         e[$];
      beat_t         held;
      int            base;
      int            waits;

      // Reset values, with upstream offering a word throughout.
      Rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      in_last  = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_push",      32'(PUSH),      32'd0);
      check("rst_pop",       32'(POP),       32'd0);
      check("rst_datain",    32'(dataIn),    32'd0);
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
      check("rst_ovf_err",   32'(ovf_err),   32'd0);
`endif
      in_valid = 1'b0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      @(negedge Clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Three-word frame with first-output latency.
      f = '{8'h11, 8'h22, 8'h33};
      base = got.size();
      build_expect(f, e);
      drive_frame(f, 1'b0);
      @(negedge Clk);
      check("lat_pop_strobe", 32'(POP), 32'd1);
      check("lat_cyc1_valid", 32'(out_valid), 32'd0);
      @(negedge Clk);
      check("lat_cyc2_valid", 32'(out_valid), 32'd0);
      @(negedge Clk);
      check("lat_cyc3_valid", 32'(out_valid), 32'd1);
      check("lat_cyc3_data",  32'(out_data),  32'h33);
      collect(base, e, "t1");

      // Single-word frame.
      f = '{8'hA5};
      run_frame(f, 1'b0, "t2");

      // Downstream stall for five cycles on the first reversed word.
      rdy_mode = 2;
      f = '{8'h31, 8'h32, 8'h33};
      base = got.size();
      build_expect(f, e);
      drive_frame(f, 1'b0);
      waits = 0;
      @(negedge Clk);
      while (!out_valid && waits < 50) begin
         waits++;
         @(negedge Clk);
      end
      held = {out_last, out_data};
      check("stall_first", 32'(held), 32'({1'b0, 8'h33}));
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         check($sformatf("stall_valid%0d", c), 32'(out_valid), 32'd1);
         check($sformatf("stall_beat%0d", c), 32'({out_last, out_data}), 32'(held));
         check($sformatf("stall_pop%0d", c), 32'(POP), 32'd0);
      end
      rdy_mode = 0;
      collect(base, e, "t3");
      check("stall_stability", 32'(stab_viol), 32'd0);

      // Frame longer than the stack: split (default) or truncated (macro).
      f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_frame(f, 1'b0, "t4");
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
      check("ovf_err_set", 32'(ovf_err), 32'd1);
`endif

      // Reset after two of three words have been pushed.
      @(posedge Clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'h41;
      in_last  = 1'b0;
      @(posedge Clk);
      #1;
      in_data = 8'h42;
      @(posedge Clk);
      #1;
      in_data = 8'h43;
      Rst     = 1'b1;
      @(negedge Clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_push",      32'(PUSH),      32'd0);
      check("mid_rst_pop",       32'(POP),       32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd0);
      in_valid = 1'b0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
`ifdef LIFO_FRAME_UNLOADER_OVF_EN
      @(negedge Clk);
      check("mid_rst_ovf_err", 32'(ovf_err), 32'd0);
`endif
      f = '{8'h07, 8'h08};
      run_frame(f, 1'b0, "t5");

      // Random frames with upstream gaps and random downstream ready.
      rdy_mode = 1;
      for (int r = 0; r < 8; r++) begin
         f.delete();
         for (int i = 0; i < int'($urandom_range(1, 9)); i++) f.push_back(DW'($urandom));
         run_frame(f, 1'b1, $sformatf("rnd%0d", r));
      end
      rdy_mode = 0;

      check("push_pop_exclusive", 32'(pushpop_viol), 32'd0);
      check("no_pop_while_valid", 32'(popsend_viol), 32'd0);
      check("final_stability",    32'(stab_viol),    32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
